imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 157 +++++++++++++++
 tb/tb_imem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch requests are served from an internal word array
// after a fixed number of wait states. Defining IMEM_RANGE_CHECK_EN adds the RSP_ERR range-check port.
module imem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int MEM_WORDS   = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  input  logic [9:0]  REQ_ADDR,
  output logic        REQ_READY,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  input  logic        RSP_READY,
  input  logic        WE,
  input  logic [9:0]  WADDR,
  input  logic [31:0] WDATA
`ifdef IMEM_RANGE_CHECK_EN
  ,
  output logic        RSP_ERR
`endif
);

  localparam int         AW        = (MEM_WORDS > 32'sd1) ? $clog2(MEM_WORDS) : 32'sd1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 32'sd0) ? 4'(WAIT_STATES - 32'sd1) : 4'd0;
  localparam logic       NO_WAIT   = (WAIT_STATES == 32'sd0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [9:0]  addr_q;
  logic [31:0] mem [MEM_WORDS];
  logic        accept;
  logic        load_rsp;
  logic        wr_en;
  logic [9:0]  rd_addr;
  logic        unused_addr_bits;

`ifdef IMEM_RANGE_CHECK_EN
  localparam logic [10:0] MEM_LIMIT = 11'(MEM_WORDS);
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  logic rd_oob;
  assign rd_oob = ({1'b0, rd_addr} >= MEM_LIMIT);
  assign wr_en  = WE && !RST && ({1'b0, WADDR} < MEM_LIMIT);
`else
  assign wr_en  = WE && !RST;
`endif

  // Upper address bits are intentionally dropped when indexing a smaller array.
  assign unused_addr_bits = ^{rd_addr, WADDR};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = NO_WAIT ? S_RESP : S_WAIT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = S_RESP;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_RESP: begin
        if (accept) begin
          next_state = NO_WAIT ? S_RESP : S_WAIT;
        end else if (RSP_READY) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_RESP;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake and response-load decode; with no wait states the read uses the live request address.
  always_comb begin
    REQ_READY = 1'b0;
    case (state)
      S_IDLE:  REQ_READY = !RST;
      S_RESP:  REQ_READY = !RST && RSP_READY;
      default: REQ_READY = 1'b0;
    endcase
    accept = REQ_VALID && REQ_READY;
    if (state == S_WAIT) begin
      load_rsp = (cnt == 4'd0);
      rd_addr  = addr_q;
    end else begin
      load_rsp = accept && NO_WAIT;
      rd_addr  = REQ_ADDR;
    end
  end

  // Wait counter, latched address and registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= 4'd0;
      addr_q    <= 10'd0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 32'h0000_0000;
`ifdef IMEM_RANGE_CHECK_EN
      RSP_ERR   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q <= REQ_ADDR;
        cnt    <= WAIT_LOAD;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (load_rsp) begin
        RSP_VALID <= 1'b1;
`ifdef IMEM_RANGE_CHECK_EN
        RSP_DATA  <= rd_oob ? NOP_WORD : mem[rd_addr[AW-1:0]];
        RSP_ERR   <= rd_oob;
`else
        RSP_DATA  <= mem[rd_addr[AW-1:0]];
`endif
      end else if ((state == S_RESP) && RSP_READY) begin
        RSP_VALID <= 1'b0;
`ifdef IMEM_RANGE_CHECK_EN
        RSP_ERR   <= 1'b0;
`endif
      end
    end
  end

  // Load port; the array has no reset so its contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[WADDR[AW-1:0]] <= WDATA;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder: one DUT with one wait state, one with none.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, we1;
  logic [9:0]  req_addr1, waddr1;
  logic [31:0] rsp_data1, wdata1;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, we0;
  logic [9:0]  req_addr0, waddr0;
  logic [31:0] rsp_data0, wdata0;
`ifdef IMEM_RANGE_CHECK_EN
  logic        rsp_err1, rsp_err0;
`endif

  int errors = 0;
  int checks = 0;

  imem_responder #(.WAIT_STATES(1), .MEM_WORDS(512)) dut1 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid1), .REQ_ADDR(req_addr1), .REQ_READY(req_ready1),
    .RSP_VALID(rsp_valid1), .RSP_DATA(rsp_data1), .RSP_READY(rsp_ready1),
    .WE(we1), .WADDR(waddr1), .WDATA(wdata1)
`ifdef IMEM_RANGE_CHECK_EN
    , .RSP_ERR(rsp_err1)
`endif
  );

  imem_responder #(.WAIT_STATES(0), .MEM_WORDS(512)) dut0 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid0), .REQ_ADDR(req_addr0), .REQ_READY(req_ready0),
    .RSP_VALID(rsp_valid0), .RSP_DATA(rsp_data0), .RSP_READY(rsp_ready0),
    .WE(we0), .WADDR(waddr0), .WDATA(wdata0)
`ifdef IMEM_RANGE_CHECK_EN
    , .RSP_ERR(rsp_err0)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [9:0] a, input logic [31:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
    tick();
    we1 = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b expected 0", req_ready1); end
    checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", req_ready0); end
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", rsp_valid1); end
    checks++; if (rsp_data1 !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000000", rsp_data1); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", req_ready1); end
  endtask

  task automatic test_wait_latency;
    write1(10'd5, 32'hDEADBEEF);
    req_valid1 = 1'b1; req_addr1 = 10'd5; rsp_ready1 = 1'b1;
    #1;
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b expected 1", req_ready1); end
    tick();
    req_valid1 = 1'b0;
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0", rsp_valid1); end
    checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL lat_wait_ready: got %b expected 0", req_ready1); end
    tick();
    checks++; if (rsp_valid1 !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", rsp_valid1); end
    checks++; if (rsp_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_data: got %h expected deadbeef", rsp_data1); end
`ifdef IMEM_RANGE_CHECK_EN
    checks++; if (rsp_err1 !== 1'b0) begin errors++; $display("FAIL lat_err: got %b expected 0", rsp_err1); end
`endif
    tick();
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL lat_drop: got %b expected 0", rsp_valid1); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      we0 = 1'b1; waddr0 = 10'(i); wdata0 = 32'h0000_0100 + 32'(i);
      tick();
    end
    we0 = 1'b0;
    rsp_ready0 = 1'b1; req_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr0 = 10'(i);
      #1;
      checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready0); end
      tick();
      checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, rsp_valid0); end
      checks++; if (rsp_data0 !== 32'h0000_0100 + 32'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rsp_data0, 32'h0000_0100 + 32'(i)); end
    end
    req_valid0 = 1'b0;
    tick();
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", rsp_valid0); end
  endtask

  task automatic test_backpressure;
    write1(10'd9, 32'hA5A5A5A5);
    req_valid1 = 1'b1; req_addr1 = 10'd9; rsp_ready1 = 1'b0;
    tick();
    req_addr1 = 10'd3;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (rsp_valid1 !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, rsp_valid1); end
      checks++; if (rsp_data1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bp_data[%0d]: got %h expected a5a5a5a5", k, rsp_data1); end
      checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, req_ready1); end
      tick();
    end
    req_valid1 = 1'b0; rsp_ready1 = 1'b1;
    #1;
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready1); end
    tick();
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL bp_consume: got %b expected 0", rsp_valid1); end
    tick(); tick();
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got %b expected 0", rsp_valid1); end
  endtask

  task automatic test_reset_mid;
    req_valid1 = 1'b1; req_addr1 = 10'd5; rsp_ready1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    rst = 1'b1; we1 = 1'b1; waddr1 = 10'd5; wdata1 = 32'h0BADF00D;
    #1;
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", rsp_valid1); end
    checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0", req_ready1); end
    tick();
    rst = 1'b0; we1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got %b expected 0", k, rsp_valid1); end
    end
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %b expected 1", req_ready1); end
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    tick();
    checks++; if (rsp_valid1 !== 1'b1) begin errors++; $display("FAIL rmid_next_valid: got %b expected 1", rsp_valid1); end
    checks++; if (rsp_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_next_data: got %h expected deadbeef", rsp_data1); end
    tick();
  endtask

  task automatic test_collision;
    write1(10'd7, 32'h22222222);
    req_valid1 = 1'b1; req_addr1 = 10'd7; rsp_ready1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    we1 = 1'b1; waddr1 = 10'd7; wdata1 = 32'h11111111;
    tick();
    we1 = 1'b0;
    checks++; if (rsp_data1 !== 32'h22222222) begin errors++; $display("FAIL coll_old: got %h expected 22222222", rsp_data1); end
    tick();
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    tick();
    checks++; if (rsp_data1 !== 32'h11111111) begin errors++; $display("FAIL coll_new: got %h expected 11111111", rsp_data1); end
    tick();
  endtask

  task automatic test_range;
    write1(10'd88, 32'hCAFE0058);
    req_valid1 = 1'b1; req_addr1 = 10'd600; rsp_ready1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    tick();
    checks++; if (rsp_valid1 !== 1'b1) begin errors++; $display("FAIL range_valid: got %b expected 1", rsp_valid1); end
`ifdef IMEM_RANGE_CHECK_EN
    checks++; if (rsp_data1 !== 32'h00000013) begin errors++; $display("FAIL range_nop: got %h expected 00000013", rsp_data1); end
    checks++; if (rsp_err1 !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", rsp_err1); end
`else
    checks++; if (rsp_data1 !== 32'hCAFE0058) begin errors++; $display("FAIL range_wrap: got %h expected cafe0058", rsp_data1); end
`endif
    tick();
    write1(10'd600, 32'h600D0600);
    req_valid1 = 1'b1; req_addr1 = 10'd88;
    tick();
    req_valid1 = 1'b0;
    tick();
`ifdef IMEM_RANGE_CHECK_EN
    checks++; if (rsp_data1 !== 32'hCAFE0058) begin errors++; $display("FAIL range_wr_drop: got %h expected cafe0058", rsp_data1); end
    checks++; if (rsp_err1 !== 1'b0) begin errors++; $display("FAIL range_err_clr: got %b expected 0", rsp_err1); end
`else
    checks++; if (rsp_data1 !== 32'h600D0600) begin errors++; $display("FAIL range_wr_wrap: got %h expected 600d0600", rsp_data1); end
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid1 = 1'b0; req_addr1 = 10'd0; rsp_ready1 = 1'b0; we1 = 1'b0; waddr1 = 10'd0; wdata1 = 32'h0;
    req_valid0 = 1'b0; req_addr0 = 10'd0; rsp_ready0 = 1'b0; we0 = 1'b0; waddr0 = 10'd0; wdata0 = 32'h0;
    test_reset();
    test_wait_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_collision();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
